data_mem_responder: RTL and testbench

- Memory-side responder for CPU load/store traffic: the target end of the data-memory interface that the CPU core drives.
- Accepts one word request at a time over a valid/ready handshake.
- Models a fixed multi-cycle access latency, then returns read data or a write acknowledge over a second valid/ready channel.
- Replaces the single-cycle data memory when the team moves to the multi-cycle and pipelined CPU with memory stalls.

---
 rtl/data_mem_responder_pkg.sv | 26 ++
 rtl/data_mem_responder_if.sv | 37 +++
 rtl/data_mem_responder_mem_word_array.sv | 39 +++
 rtl/data_mem_responder.sv | 118 +++++++++++
 tb/tb_data_mem_responder.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_responder_pkg.sv
// ----------------------------------------------------------------------------
// data_mem_responder_pkg
// Shared types and constants for the multi-cycle data-memory responder.
//   state_t    : responder FSM state (IDLE / BUSY / RESP), 2-bit encoding
//   WORD_W     : data word width in bits
//   BYTE_OFF_W : number of byte-offset bits below the word index
//   CNT_W      : latency counter width (covers LATENCY up to 15)
//   is_aligned : true when a byte address falls on a word boundary
// ----------------------------------------------------------------------------
package data_mem_responder_pkg;

  localparam int WORD_W     = 32;
  localparam int BYTE_OFF_W = 2;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic is_aligned(input logic [BYTE_OFF_W-1:0] off);
    return (off == '0);
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// ----------------------------------------------------------------------------
// data_mem_responder_if
// CPU <-> data memory bus: a request channel and a response channel.
//
// Handshake rule (both channels): a transfer happens on a rising clock edge
// where valid && ready are both high. The source holds valid and its payload
// stable until that edge; ready may change freely and does not depend on
// valid of the same channel.
//
//   master (CPU)     : drives req_valid/req_write/req_addr/req_wdata and
//                      resp_ready; observes req_ready and the response.
//   slave (responder): the mirror image.
// ----------------------------------------------------------------------------
interface data_mem_responder_if;
  import data_mem_responder_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [WORD_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/data_mem_responder_mem_word_array.sv
// ----------------------------------------------------------------------------
// mem_word_array
// Word storage: synchronous write, combinational read, whole array cleared
// on a reset edge. Read and write share one index.
//   clk     : clock
//   reset   : synchronous active-high clear of every word
//   i_we    : write enable (ignored while reset is high)
//   i_idx   : word index for both ports
//   i_wdata : write data
//   o_rdata : word currently stored at i_idx
// ----------------------------------------------------------------------------
module mem_word_array
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH = 16384
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_idx,
  input  logic [WORD_W-1:0]        i_wdata,
  output logic [WORD_W-1:0]        o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
// Target end of the CPU data-memory bus. Accepts one word request at a time,
// waits LATENCY cycles, performs the access, then offers the response until
// the CPU takes it.
//   clk         : clock
//   reset       : synchronous active-high reset (drops any in-flight request)
//   bus         : request/response channels (slave side)
//   busy        : high while a request is in flight or its response waits
//   o_dbg_state : current FSM state
// Parameters:
//   DEPTH_WORDS : number of stored words (power of two)
//   LATENCY     : cycles from accept edge to first resp_valid (1..15)
// ----------------------------------------------------------------------------
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 16384,
  parameter int LATENCY     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus,
  output logic                 busy,
  output state_t               o_dbg_state
);

  localparam int              IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LATENCY - 1);

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_write;
  logic [IDX_W-1:0]        r_idx;
  logic [BYTE_OFF_W-1:0]   r_off;
  logic [WORD_W-1:0]       r_wdata;
  logic [WORD_W-1:0]       r_resp_rdata;
  logic                    r_resp_err;

  logic                    w_access;
  logic                    w_aligned;
  logic                    w_we;
  logic [WORD_W-1:0]       w_rdata;

  // Only the index bits and the byte offset are kept; higher address bits
  // are dropped at accept, which is what makes addresses wrap.
  assign w_aligned = is_aligned(r_off);
  assign w_access  = (r_state == ST_BUSY) && (r_cnt == '0);
  assign w_we      = w_access && r_write && w_aligned;

  mem_word_array #(
    .DEPTH (DEPTH_WORDS)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_we),
    .i_idx   (r_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_write      <= 1'b0;
      r_idx        <= '0;
      r_off        <= '0;
      r_wdata      <= '0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // req_ready is high throughout IDLE, so valid alone is an accept.
          if (bus.req_valid) begin
            r_write <= bus.req_write;
            r_idx   <= bus.req_addr[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W];
            r_off   <= bus.req_addr[BYTE_OFF_W-1:0];
            r_wdata <= bus.req_wdata;
            r_cnt   <= LOAD_CNT;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (r_cnt == '0) begin
            // Access edge: the store (if any) commits in u_mem on this edge.
            r_resp_err   <= ~w_aligned;
            r_resp_rdata <= (w_aligned && !r_write) ? w_rdata : '0;
            r_state      <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Ready and valid decode from mutually exclusive states, so they can
  // never be high together.
  assign bus.req_ready  = (r_state == ST_IDLE);
  assign bus.resp_valid = (r_state == ST_RESP);
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;
  assign busy           = (r_state != ST_IDLE);
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  data_mem_responder_if b0 ();
  data_mem_responder_if b1 ();
  logic   busy0, busy1;
  state_t st0, st1;

  data_mem_responder #(.DEPTH_WORDS(16384), .LATENCY(4)) dut0 (
    .clk(clk), .reset(reset), .bus(b0), .busy(busy0), .o_dbg_state(st0)
  );

  data_mem_responder #(.DEPTH_WORDS(16384), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .bus(b1), .busy(busy1), .o_dbg_state(st1)
  );

  // accept-edge recorder (cycle numbers of request handshakes)
  int acc0_q[$];
  int acc1_q[$];
  logic [31:0] exp_q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && b0.req_valid && b0.req_ready) acc0_q.push_back(cyc);
    if (!reset && b1.req_valid && b1.req_ready) acc1_q.push_back(cyc);
  end

  // ---------------- driver tasks (dut0) ----------------
  // Caller is #1 after a rising edge. Returns cycles from accept edge to
  // the first sample where resp_valid is seen (capped at 40 on timeout).
  task automatic send_req(input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, output int lat);
    int guard;
    guard = 0;
    while (!b0.req_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    b0.req_valid = 1'b1;
    b0.req_write = wr;
    b0.req_addr  = addr;
    b0.req_wdata = wd;
    @(posedge clk); #1;
    b0.req_valid = 1'b0;
    b0.req_write = 1'b0;
    b0.req_addr  = '0;
    b0.req_wdata = '0;
    lat = 0;
    while (!b0.resp_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic take_resp(output logic [31:0] rd, output logic er);
    rd = b0.resp_rdata;
    er = b0.resp_err;
    b0.resp_ready = 1'b1;
    @(posedge clk); #1;
    b0.resp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    n_cmp++; if (b0.req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got=%b exp=1", b0.req_ready); end
    n_cmp++; if (b0.resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid got=%b exp=0", b0.resp_valid); end
    n_cmp++; if (b0.resp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got=%h exp=0", b0.resp_rdata); end
    n_cmp++; if (b0.resp_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", b0.resp_err); end
    n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy0); end
    n_cmp++; if (st0 !== ST_IDLE) begin n_bad++; $display("FAIL reset_state got=%0d exp=%0d", st0, ST_IDLE); end
  endtask

  task automatic test_store_load;
    int lat; logic [31:0] rd; logic er;
    send_req(1'b1, 32'h100, 32'hDEADBEEF, lat);
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL store_latency got=%0d exp=4", lat); end
    n_cmp++; if (busy0 !== 1'b1) begin n_bad++; $display("FAIL store_busy_in_resp got=%b exp=1", busy0); end
    n_cmp++; if (b0.req_ready !== 1'b0) begin n_bad++; $display("FAIL store_req_ready_in_resp got=%b exp=0", b0.req_ready); end
    take_resp(rd, er);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL store_rdata got=%h exp=0", rd); end
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL store_err got=%b exp=0", er); end
    n_cmp++; if (b0.resp_valid !== 1'b0) begin n_bad++; $display("FAIL store_valid_after_hs got=%b exp=0", b0.resp_valid); end
    n_cmp++; if (b0.req_ready !== 1'b1) begin n_bad++; $display("FAIL store_ready_after_hs got=%b exp=1", b0.req_ready); end
    send_req(1'b0, 32'h100, 32'h0, lat);
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL load_latency got=%0d exp=4", lat); end
    take_resp(rd, er);
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL load_rdata got=%h exp=deadbeef", rd); end
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL load_err got=%b exp=0", er); end
  endtask

  task automatic test_backpressure;
    int lat; logic [31:0] rd; logic er;
    send_req(1'b0, 32'h100, 32'h0, lat);
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL bp_latency got=%0d exp=4", lat); end
    b0.req_valid = 1'b1;   // a second request waiting must not be taken
    b0.req_addr  = 32'h104;
    for (int k = 0; k < 6; k++) begin
      n_cmp++; if (b0.resp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid_held[%0d] got=%b exp=1", k, b0.resp_valid); end
      n_cmp++; if (b0.resp_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL bp_rdata_held[%0d] got=%h exp=deadbeef", k, b0.resp_rdata); end
      n_cmp++; if (b0.req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_req_ready[%0d] got=%b exp=0", k, b0.req_ready); end
      @(posedge clk); #1;
    end
    b0.req_valid = 1'b0;
    b0.req_addr  = '0;
    take_resp(rd, er);
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL bp_rdata got=%h exp=deadbeef", rd); end
    n_cmp++; if (st0 !== ST_IDLE) begin n_bad++; $display("FAIL bp_state_after_hs got=%0d exp=%0d", st0, ST_IDLE); end
    n_cmp++; if (b0.req_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_after_hs got=%b exp=1", b0.req_ready); end
  endtask

  task automatic test_misaligned;
    int lat; logic [31:0] rd; logic er;
    send_req(1'b1, 32'h102, 32'h12345678, lat);
    take_resp(rd, er);
    n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL mis_store_err got=%b exp=1", er); end
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL mis_store_rdata got=%h exp=0", rd); end
    send_req(1'b0, 32'h101, 32'h0, lat);
    take_resp(rd, er);
    n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL mis_load_err got=%b exp=1", er); end
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL mis_load_rdata got=%h exp=0", rd); end
    send_req(1'b0, 32'h100, 32'h0, lat);
    take_resp(rd, er);
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL mis_no_write got=%h exp=deadbeef", rd); end
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL mis_followup_err got=%b exp=0", er); end
  endtask

  task automatic test_wrap;
    int lat; logic [31:0] rd; logic er;
    send_req(1'b1, 32'h0001_0000, 32'hA5A5A5A5, lat);
    take_resp(rd, er);
    send_req(1'b0, 32'h0, 32'h0, lat);
    take_resp(rd, er);
    n_cmp++; if (rd !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL wrap_load0 got=%h exp=a5a5a5a5", rd); end
    send_req(1'b0, 32'hFFFF_0100, 32'h0, lat);
    take_resp(rd, er);
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wrap_high_bits got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_back_to_back;
    int nresp; int sp; logic [31:0] got; logic [31:0] exp_v;
    acc0_q.delete();
    exp_q.delete();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'hCAFEF00D);
    nresp = 0;
    b0.resp_ready = 1'b1;
    for (int k = 0; k < 40 && nresp < 2; k++) begin
      case (acc0_q.size())
        0: begin b0.req_valid = 1'b1; b0.req_write = 1'b1; b0.req_addr = 32'h300; b0.req_wdata = 32'hCAFEF00D; end
        1: begin b0.req_valid = 1'b1; b0.req_write = 1'b0; b0.req_addr = 32'h300; b0.req_wdata = 32'h0; end
        default: begin b0.req_valid = 1'b0; b0.req_write = 1'b0; b0.req_addr = '0; b0.req_wdata = '0; end
      endcase
      if (b0.resp_valid) begin
        got = b0.resp_rdata;
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
        n_cmp++; if (got !== exp_v) begin n_bad++; $display("FAIL b2b_rdata[%0d] got=%h exp=%h", nresp, got, exp_v); end
        nresp++;
      end
      @(posedge clk); #1;
    end
    b0.req_valid = 1'b0;
    b0.resp_ready = 1'b0;
    n_cmp++; if (nresp !== 2) begin n_bad++; $display("FAIL b2b_resp_count got=%0d exp=2", nresp); end
    sp = (acc0_q.size() >= 2) ? (acc0_q[1] - acc0_q[0]) : -1;
    n_cmp++; if (sp !== 6) begin n_bad++; $display("FAIL b2b_spacing got=%0d exp=6", sp); end
  endtask

  task automatic test_reset_midop;
    int seen; int lat; logic [31:0] rd; logic er;
    b0.req_valid = 1'b1; b0.req_write = 1'b1; b0.req_addr = 32'h200; b0.req_wdata = 32'h11111111;
    @(posedge clk); #1;
    b0.req_valid = 1'b0; b0.req_write = 1'b0; b0.req_addr = '0; b0.req_wdata = '0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got=%b exp=0", busy0); end
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (b0.resp_valid) seen++;
      @(posedge clk); #1;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL midrst_no_resp got=%0d exp=0", seen); end
    send_req(1'b0, 32'h200, 32'h0, lat);
    take_resp(rd, er);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL midrst_no_commit got=%h exp=0", rd); end
    send_req(1'b0, 32'h100, 32'h0, lat);
    take_resp(rd, er);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL midrst_mem_cleared got=%h exp=0", rd); end
  endtask

  task automatic test_latency1;
    int lat; int nresp; int sp; logic [31:0] got; logic [31:0] exp_v;
    b1.req_valid = 1'b1; b1.req_write = 1'b0; b1.req_addr = 32'h40; b1.req_wdata = '0;
    @(posedge clk); #1;
    b1.req_valid = 1'b0; b1.req_addr = '0;
    lat = 0;
    while (!b1.resp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL l1_latency got=%0d exp=1", lat); end
    n_cmp++; if (b1.resp_rdata !== 32'h0) begin n_bad++; $display("FAIL l1_rdata got=%h exp=0", b1.resp_rdata); end
    b1.resp_ready = 1'b1;
    @(posedge clk); #1;
    acc1_q.delete();
    exp_q.delete();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h00000077);
    nresp = 0;
    for (int k = 0; k < 40 && nresp < 2; k++) begin
      case (acc1_q.size())
        0: begin b1.req_valid = 1'b1; b1.req_write = 1'b1; b1.req_addr = 32'h44; b1.req_wdata = 32'h77; end
        1: begin b1.req_valid = 1'b1; b1.req_write = 1'b0; b1.req_addr = 32'h44; b1.req_wdata = 32'h0; end
        default: begin b1.req_valid = 1'b0; b1.req_write = 1'b0; b1.req_addr = '0; b1.req_wdata = '0; end
      endcase
      if (b1.resp_valid) begin
        got = b1.resp_rdata;
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
        n_cmp++; if (got !== exp_v) begin n_bad++; $display("FAIL l1_b2b_rdata[%0d] got=%h exp=%h", nresp, got, exp_v); end
        nresp++;
      end
      @(posedge clk); #1;
    end
    b1.req_valid = 1'b0;
    b1.resp_ready = 1'b0;
    n_cmp++; if (nresp !== 2) begin n_bad++; $display("FAIL l1_resp_count got=%0d exp=2", nresp); end
    sp = (acc1_q.size() >= 2) ? (acc1_q[1] - acc1_q[0]) : -1;
    n_cmp++; if (sp !== 3) begin n_bad++; $display("FAIL l1_spacing got=%0d exp=3", sp); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    b0.req_valid = 1'b0; b0.req_write = 1'b0; b0.req_addr = '0; b0.req_wdata = '0; b0.resp_ready = 1'b0;
    b1.req_valid = 1'b0; b1.req_write = 1'b0; b1.req_addr = '0; b1.req_wdata = '0; b1.resp_ready = 1'b0;
    test_reset();
    test_store_load();
    test_backpressure();
    test_misaligned();
    test_wrap();
    test_back_to_back();
    test_reset_midop();
    test_latency1();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
